// File: rtl/mips_pipe_pkg.sv
// Shared types for the MEM->WB pipeline buffer: state encoding and write-back payload.
package mips_pipe_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEST_W = 5;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic                      WB_en;
        logic                      MEM_R_EN;
        logic [DEFAULT_DATA_W-1:0] ALU_result;
        logic [DEFAULT_DATA_W-1:0] Mem_read_value;
        logic [DEFAULT_DEST_W-1:0] Dest;
    } mem_wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Payload-agnostic valid/ready stage: one head register plus an optional skid entry.
module pipe_skid_buf
    import mips_pipe_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter bit          SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    buf_state_e   r_state;
    buf_state_e   w_next_state;
    logic         r_out_valid;
    logic         r_in_ready;
    logic [W-1:0] r_head;
    logic [W-1:0] r_skid;

    logic w_accept;
    logic w_retire;
    logic w_load_head_in;
    logic w_load_head_skid;
    logic w_load_skid;

    // With the skid entry in_ready comes from a flop; without it, it looks through to out_ready.
    assign in_ready  = SKID ? r_in_ready : (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_retire  = r_out_valid && out_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;
    assign occupancy = 2'(r_state);

    // Next-state and register-load decisions; flush overrides any handshake.
    always_comb begin
        w_next_state     = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next_state   = ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_retire) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept && SKID) begin
                        w_next_state = TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_retire) begin
                        w_next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (w_retire) begin
                        w_next_state     = ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    // State, registered handshake outputs and payload storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != EMPTY);
            r_in_ready  <= (w_next_state != TWO);
            if (w_load_head_in) begin
                r_head <= in_data;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe_buf.sv
// MEM->WB stage register: packs the write-back payload, selects WB_value and drives the forwarding tap.
module mem_wb_pipe_buf
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEST_W = DEFAULT_DEST_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] Mem_read_value_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] Mem_read_value,
    output logic [DEST_W-1:0] Dest,
    output logic [DATA_W-1:0] WB_value,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_value,
    output logic [1:0]        occupancy
);

    localparam int unsigned PAYLOAD_W = $bits(mem_wb_payload_t);

    mem_wb_payload_t             w_in_payload;
    mem_wb_payload_t             w_head;
    logic [DEFAULT_DATA_W-1:0]   w_wb_value;

    // Stored payload uses the package field widths; ports are cast onto them.
    assign w_in_payload = '{
        WB_en:          WB_en_in,
        MEM_R_EN:       MEM_R_EN_in,
        ALU_result:     DEFAULT_DATA_W'(ALU_result_in),
        Mem_read_value: DEFAULT_DATA_W'(Mem_read_value_in),
        Dest:           DEFAULT_DEST_W'(Dest_in)
    };

    pipe_skid_buf #(
        .W    (PAYLOAD_W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_head),
        .occupancy (occupancy)
    );

    // Loads write memory data, everything else writes the ALU result.
    assign w_wb_value = w_head.MEM_R_EN ? w_head.Mem_read_value : w_head.ALU_result;

    // A flushed or empty slot never writes, so the enable is qualified by out_valid.
    assign WB_en          = out_valid && w_head.WB_en;
    assign MEM_R_EN       = w_head.MEM_R_EN;
    assign ALU_result     = DATA_W'(w_head.ALU_result);
    assign Mem_read_value = DATA_W'(w_head.Mem_read_value);
    assign Dest           = DEST_W'(w_head.Dest);
    assign WB_value       = DATA_W'(w_wb_value);

    // The zero register is never a forwarding source.
    assign fwd_valid = out_valid && w_head.WB_en && (w_head.Dest != '0);
    assign fwd_dest  = Dest;
    assign fwd_value = WB_value;

endmodule

// File: tb/tb_mem_wb_pipe_buf.sv
// Scoreboard bench for mem_wb_pipe_buf (skid version) plus directed checks of the SKID=0 variant.
module tb_mem_wb_pipe_buf;

    typedef struct {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dest;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_valid0 = 1'b0;
    logic        out_ready0 = 1'b1;
    logic        WB_en_in = 1'b0;
    logic        MEM_R_EN_in = 1'b0;
    logic [31:0] ALU_result_in = '0;
    logic [31:0] Mem_read_value_in = '0;
    logic [4:0]  Dest_in = '0;

    logic        in_ready, out_valid, WB_en, MEM_R_EN, fwd_valid;
    logic [31:0] ALU_result, Mem_read_value, WB_value, fwd_value;
    logic [4:0]  Dest, fwd_dest;
    logic [1:0]  occupancy;

    logic        in_ready_0, out_valid_0, WB_en_0, MEM_R_EN_0, fwd_valid_0;
    logic [31:0] ALU_result_0, Mem_read_value_0, WB_value_0, fwd_value_0;
    logic [4:0]  Dest_0, fwd_dest_0;
    logic [1:0]  occupancy_0;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_buf #(.DATA_W(32), .DEST_W(5), .SKID(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
        .ALU_result_in(ALU_result_in), .Mem_read_value_in(Mem_read_value_in), .Dest_in(Dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .Mem_read_value(Mem_read_value), .Dest(Dest), .WB_value(WB_value),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value),
        .occupancy(occupancy)
    );

    mem_wb_pipe_buf #(.DATA_W(32), .DEST_W(5), .SKID(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready_0),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
        .ALU_result_in(ALU_result_in), .Mem_read_value_in(Mem_read_value_in), .Dest_in(Dest_in),
        .out_valid(out_valid_0), .out_ready(out_ready0),
        .WB_en(WB_en_0), .MEM_R_EN(MEM_R_EN_0), .ALU_result(ALU_result_0),
        .Mem_read_value(Mem_read_value_0), .Dest(Dest_0), .WB_value(WB_value_0),
        .fwd_valid(fwd_valid_0), .fwd_dest(fwd_dest_0), .fwd_value(fwd_value_0),
        .occupancy(occupancy_0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat from posedge+1, wait (bounded) for in_ready, record the expectation.
    task automatic send(input logic wb, input logic mr, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [4:0] dest, output int waits);
        exp_t e;
        in_valid          = 1'b1;
        WB_en_in          = wb;
        MEM_R_EN_in       = mr;
        ALU_result_in     = alu;
        Mem_read_value_in = mem;
        Dest_in           = dest;
        waits             = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, want 1", waits);
        end else begin
            e.wb = wb; e.mr = mr; e.alu = alu; e.mem = mem; e.dest = dest;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare each retired beat with the scoreboard head; check a stalled head stays put.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: Dest=%0d emitted, want nothing", Dest);
            end else begin
                mon_e = sb.pop_front();
                check("sb_dest", 32'(Dest), 32'(mon_e.dest));
                check("sb_wb_value", WB_value, mon_e.mr ? mon_e.mem : mon_e.alu);
                check("sb_wb_en", 32'(WB_en), 32'(mon_e.wb));
                check("sb_fwd_valid", 32'(fwd_valid), 32'(mon_e.wb && (mon_e.dest != 5'd0)));
            end
        end else if (out_valid && sb.size() != 0) begin
            check("hold_dest", 32'(Dest), 32'(sb[0].dest));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #1 rst = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_wb_en", 32'(WB_en), 0);
        check("rst_in_ready_skid0", 32'(in_ready_0), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming, one beat per cycle
        out_ready = 1'b1;
        for (int d = 1; d <= 8; d++) begin
            send(1'b1, 1'(d & 1), 32'(d) << 4, 32'hA000_0000 | 32'(d), 5'(d), w);
            check("stream_no_bubble", 32'(w), 0);
            check("stream_latency_dest", 32'(Dest), 32'(d));
            check("stream_occupancy", 32'(occupancy), 1);
        end
        @(posedge clk);
        #1;
        check("stream_drained", 32'(occupancy), 0);

        // Back-pressure fills the skid entry
        out_ready = 1'b0;
        send(1'b1, 1'b0, 32'h0000_0003, 32'h0, 5'd3, w);
        send(1'b1, 1'b0, 32'h0000_0004, 32'h0, 5'd4, w);
        check("bp_occupancy", 32'(occupancy), 2);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_head", 32'(Dest), 3);
        repeat (2) @(posedge clk);
        #1;
        check("bp_head_held", 32'(Dest), 3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_second", 32'(Dest), 4);
        check("bp_in_ready_back", 32'(in_ready), 1);
        check("bp_occ_one", 32'(occupancy), 1);
        @(posedge clk);
        #1;
        check("bp_drained", 32'(occupancy), 0);

        // Flush with two held and a beat offered
        out_ready = 1'b0;
        send(1'b1, 1'b0, 32'h30, 32'h0, 5'd10, w);
        send(1'b1, 1'b0, 32'h31, 32'h0, 5'd11, w);
        check("flush2_pre_occ", 32'(occupancy), 2);
        flush = 1'b1; in_valid = 1'b1; WB_en_in = 1'b1; MEM_R_EN_in = 1'b0;
        ALU_result_in = 32'h77; Dest_in = 5'd7;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush2_out_valid", 32'(out_valid), 0);
        check("flush2_occupancy", 32'(occupancy), 0);
        check("flush2_wb_en", 32'(WB_en), 0);
        check("flush2_fwd_valid", 32'(fwd_valid), 0);
        check("flush2_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush2_quiet", 32'(out_valid), 0);

        // Flush discards a same-cycle accept
        out_ready = 1'b0;
        send(1'b1, 1'b0, 32'h40, 32'h0, 5'd12, w);
        flush = 1'b1; in_valid = 1'b1; Dest_in = 5'd7; ALU_result_in = 32'h77;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush1_occupancy", 32'(occupancy), 0);
        check("flush1_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush1_quiet", 32'(out_valid), 0);

        // Flush with a same-cycle retire: the head still goes to WB
        send(1'b1, 1'b0, 32'h50, 32'h0, 5'd13, w);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_retire_popped", 32'(sb.size()), 0);
        check("flush_retire_empty", 32'(out_valid), 0);

        // Load select
        send(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 5'd6, w);
        check("load_wb_value", WB_value, 32'hDEAD_BEEF);
        check("load_mem_r_en", 32'(MEM_R_EN), 1);
        check("load_alu", ALU_result, 32'h100);
        check("load_mem", Mem_read_value, 32'hDEAD_BEEF);
        send(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd6, w);
        check("alu_wb_value", WB_value, 32'h100);

        // Forwarding tap
        send(1'b1, 1'b0, 32'h11, 32'h0, 5'd0, w);
        check("fwd_r0_valid", 32'(fwd_valid), 0);
        check("fwd_r0_wb_en", 32'(WB_en), 1);
        send(1'b1, 1'b0, 32'h22, 32'h0, 5'd5, w);
        check("fwd_r5_valid", 32'(fwd_valid), 1);
        check("fwd_r5_dest", 32'(fwd_dest), 5);
        check("fwd_r5_value", fwd_value, 32'h22);
        send(1'b0, 1'b0, 32'h33, 32'h0, 5'd5, w);
        check("fwd_nowb_valid", 32'(fwd_valid), 0);
        check("fwd_nowb_wb_en", 32'(WB_en), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(1'b1, 1'b0, 32'h20, 32'h0, 5'd20, w);
        send(1'b1, 1'b0, 32'h21, 32'h0, 5'd21, w);
        check("rst2_pre_occ", 32'(occupancy), 2);
        #2;
        rst = 1'b0;
        #1;
        check("rst2_out_valid", 32'(out_valid), 0);
        check("rst2_wb_en", 32'(WB_en), 0);
        check("rst2_occupancy", 32'(occupancy), 0);
        check("rst2_dest", 32'(Dest), 0);
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_in_ready", 32'(in_ready), 1);
        check("rst2_occ_after", 32'(occupancy), 0);

        // SKID=0: in_ready follows out_ready combinationally
        out_ready0 = 1'b0; in_valid0 = 1'b1;
        WB_en_in = 1'b1; MEM_R_EN_in = 1'b0; ALU_result_in = 32'h90;
        Mem_read_value_in = 32'h900; Dest_in = 5'd9;
        #1;
        check("s0_ready_empty", 32'(in_ready_0), 1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        check("s0_out_valid", 32'(out_valid_0), 1);
        check("s0_dest", 32'(Dest_0), 9);
        check("s0_occ", 32'(occupancy_0), 1);
        check("s0_ready_stall", 32'(in_ready_0), 0);
        check("s0_wb_en", 32'(WB_en_0), 1);
        check("s0_mem_r_en", 32'(MEM_R_EN_0), 0);
        check("s0_alu", ALU_result_0, 32'h90);
        check("s0_mem", Mem_read_value_0, 32'h900);
        check("s0_wb_value", WB_value_0, 32'h90);
        check("s0_fwd_valid", 32'(fwd_valid_0), 1);
        check("s0_fwd_dest", 32'(fwd_dest_0), 9);
        check("s0_fwd_value", fwd_value_0, 32'h90);
        out_ready0 = 1'b1;
        #1;
        check("s0_ready_follows_1", 32'(in_ready_0), 1);
        out_ready0 = 1'b0;
        #1;
        check("s0_ready_follows_0", 32'(in_ready_0), 0);
        in_valid0 = 1'b1; Dest_in = 5'd10;
        @(posedge clk);
        #1;
        check("s0_no_accept_dest", 32'(Dest_0), 9);
        check("s0_no_accept_occ", 32'(occupancy_0), 1);
        out_ready0 = 1'b1;
        #1;
        check("s0_ready_again", 32'(in_ready_0), 1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        check("s0_pass_dest", 32'(Dest_0), 10);
        check("s0_pass_occ", 32'(occupancy_0), 1);
        @(posedge clk);
        #1;
        check("s0_drained", 32'(occupancy_0), 0);
        check("s0_drained_valid", 32'(out_valid_0), 0);

        check("sb_leftover", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
